// File: rtl/decode_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// decode_stage_pipe_if : fetch/writeback-to-decode bundle and decoded outputs
// ---------------------------------------------------------------------------
`default_nettype none

interface decode_stage_pipe_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [31:0]       instruction;
  logic              stall_in;
  logic              flush;
  logic              wb_we;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;

  logic              hazard_stall;
  logic              out_valid;
  logic [5:0]        out_opcode;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_rd;
  logic [DATA_W-1:0] out_rd1;
  logic [DATA_W-1:0] out_rd2;
  logic [DATA_W-1:0] out_imm;

  // master drives instructions and writebacks; slave is the decode stage
  modport master (
    output in_valid, instruction, stall_in, flush, wb_we, wb_reg, wb_data,
    input  hazard_stall, out_valid, out_opcode, out_rs, out_rt, out_rd,
           out_rd1, out_rd2, out_imm
  );

  modport slave (
    input  in_valid, instruction, stall_in, flush, wb_we, wb_reg, wb_data,
    output hazard_stall, out_valid, out_opcode, out_rs, out_rt, out_rd,
           out_rd1, out_rd2, out_imm
  );
endinterface

`default_nettype wire

// File: rtl/decode_stage_pipe.sv
// ---------------------------------------------------------------------------
// decode_stage_pipe : MIPS decode with 32-entry regfile, imm extend, load-use stall
// ---------------------------------------------------------------------------
`default_nettype none

module decode_stage_pipe #(
  parameter int          DATA_W     = 32,
  parameter int          ZEXT_LOGIC = 1,
  parameter logic [5:0]  LOAD_OPC   = 6'h23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decode_stage_pipe_if.slave    bus
);

  localparam logic [5:0] c_OPC_ANDI = 6'h0C;
  localparam logic [5:0] c_OPC_ORI  = 6'h0D;
  localparam logic [5:0] c_OPC_XORI = 6'h0E;

  logic [DATA_W-1:0] rf_q [32];

  logic              out_valid_q;
  logic [5:0]        out_opcode_q;
  logic [4:0]        out_rs_q, out_rt_q, out_rd_q;
  logic [DATA_W-1:0] out_rd1_q, out_rd2_q, out_imm_q;

  logic [5:0]        opcode_d;
  logic [4:0]        rs_d, rt_d, rd_d;
  logic [DATA_W-1:0] rd1_d, rd2_d, imm_d;
  logic              zext_d;
  logic              hazard_d;

  assign opcode_d = bus.instruction[31:26];
  assign rs_d     = bus.instruction[25:21];
  assign rt_d     = bus.instruction[20:16];
  assign rd_d     = bus.instruction[15:11];

  // Reads see a same-cycle writeback so the writer need not wait an extra cycle
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs_d != 5'd0) begin
      rd1_d = (bus.wb_we && bus.wb_reg == rs_d) ? bus.wb_data : rf_q[rs_d];
    end
    if (rt_d != 5'd0) begin
      rd2_d = (bus.wb_we && bus.wb_reg == rt_d) ? bus.wb_data : rf_q[rt_d];
    end
  end

  assign zext_d = (ZEXT_LOGIC != 0) &&
                  (opcode_d == c_OPC_ANDI || opcode_d == c_OPC_ORI || opcode_d == c_OPC_XORI);
  assign imm_d  = zext_d ? {{(DATA_W-16){1'b0}}, bus.instruction[15:0]}
                         : {{(DATA_W-16){bus.instruction[15]}}, bus.instruction[15:0]};

  assign hazard_d = bus.in_valid && out_valid_q && (out_opcode_q == LOAD_OPC) &&
                    (out_rt_q != 5'd0) &&
                    (out_rt_q == rs_d || out_rt_q == rt_d) && !bus.flush;

  // Register file: writes ignore pipeline control, only reset stops them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (bus.wb_we && bus.wb_reg != 5'd0) begin
      rf_q[bus.wb_reg] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_opcode_q <= '0;
      out_rs_q     <= '0;
      out_rt_q     <= '0;
      out_rd_q     <= '0;
      out_rd1_q    <= '0;
      out_rd2_q    <= '0;
      out_imm_q    <= '0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
    end else if (bus.stall_in) begin
      out_valid_q  <= out_valid_q;
    end else if (hazard_d) begin
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q  <= bus.in_valid;
      out_opcode_q <= opcode_d;
      out_rs_q     <= rs_d;
      out_rt_q     <= rt_d;
      out_rd_q     <= rd_d;
      out_rd1_q    <= rd1_d;
      out_rd2_q    <= rd2_d;
      out_imm_q    <= imm_d;
    end
  end

  assign bus.hazard_stall = hazard_d;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_opcode   = out_opcode_q;
  assign bus.out_rs       = out_rs_q;
  assign bus.out_rt       = out_rt_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_rd1      = out_rd1_q;
  assign bus.out_rd2      = out_rd2_q;
  assign bus.out_imm      = out_imm_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_pipe : directed self-checking bench for decode_stage_pipe
// ---------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage_pipe;

  localparam int c_DW = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  decode_stage_pipe_if #(.DATA_W(c_DW)) bus ();

  decode_stage_pipe #(
    .DATA_W     (c_DW),
    .ZEXT_LOGIC (1),
    .LOAD_OPC   (6'h23)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // outputs are sampled and inputs changed 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.instruction  = '0;
    bus.stall_in     = 1'b0;
    bus.flush        = 1'b0;
    bus.wb_we        = 1'b0;
    bus.wb_reg       = '0;
    bus.wb_data      = '0;
    tick();
    tick();
    check_val("rst_valid", bus.out_valid, 0);
    check_val("rst_rd1",   bus.out_rd1, 0);
    check_val("rst_imm",   bus.out_imm, 0);
    check_val("rst_hazard", bus.hazard_stall, 0);
    rst_n = 1'b1;

    // register writes, r0 write must be ignored
    bus.wb_we = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'h1234;
    tick();
    bus.wb_reg = 5'd0; bus.wb_data = 32'hFFFF;
    tick();
    bus.wb_we = 1'b0;
    bus.in_valid = 1'b1; bus.instruction = rtype(5'd5, 5'd0, 5'd3);
    tick();
    check_val("add_valid", bus.out_valid, 1);
    check_val("add_rd1",   bus.out_rd1, 32'h1234);
    check_val("add_rd2",   bus.out_rd2, 0);
    check_val("add_rd",    bus.out_rd, 3);
    bus.instruction = rtype(5'd0, 5'd0, 5'd1);
    tick();
    check_val("r0_read", bus.out_rd1, 0);

    // same-cycle writeback bypass
    bus.wb_we = 1'b1; bus.wb_reg = 5'd7; bus.wb_data = 32'hABCD;
    bus.instruction = rtype(5'd7, 5'd5, 5'd1);
    tick();
    bus.wb_we = 1'b0;
    check_val("bypass_rd1", bus.out_rd1, 32'hABCD);
    check_val("bypass_rd2", bus.out_rd2, 32'h1234);

    // immediate extension
    bus.instruction = itype(6'h08, 5'd0, 5'd1, 16'h8001);
    tick();
    check_val("addi_imm", bus.out_imm, 32'hFFFF8001);
    bus.instruction = itype(6'h0D, 5'd0, 5'd1, 16'h8001);
    tick();
    check_val("ori_imm", bus.out_imm, 32'h00008001);
    check_val("ori_opc", bus.out_opcode, 6'h0D);
    bus.instruction = itype(6'h0C, 5'd0, 5'd1, 16'hF00F);
    tick();
    check_val("andi_imm", bus.out_imm, 32'h0000F00F);

    // load-use hazard
    bus.instruction = itype(6'h23, 5'd1, 5'd4, 16'h0000);
    tick();
    check_val("lw_valid", bus.out_valid, 1);
    bus.instruction = rtype(5'd4, 5'd3, 5'd2);
    #1;
    check_val("hz_on", bus.hazard_stall, 1);
    tick();
    check_val("hz_bubble", bus.out_valid, 0);
    check_val("hz_off", bus.hazard_stall, 0);
    tick();
    check_val("hz_issue_valid", bus.out_valid, 1);
    check_val("hz_issue_rs", bus.out_rs, 4);
    check_val("hz_issue_rd", bus.out_rd, 2);

    // load to r0 never stalls
    bus.instruction = itype(6'h23, 5'd1, 5'd0, 16'h0000);
    tick();
    bus.instruction = rtype(5'd0, 5'd3, 5'd2);
    #1;
    check_val("hz_r0", bus.hazard_stall, 0);
    tick();
    check_val("hz_r0_valid", bus.out_valid, 1);
    check_val("hz_r0_rd", bus.out_rd, 2);

    // downstream stall holds outputs; writes still land
    bus.instruction = rtype(5'd5, 5'd0, 5'd6);
    tick();
    check_val("pre_stall_rd1", bus.out_rd1, 32'h1234);
    bus.stall_in = 1'b1;
    bus.instruction = rtype(5'd7, 5'd7, 5'd9);
    bus.wb_we = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.wb_we = 1'b0;
      check_val("stall_valid", bus.out_valid, 1);
      check_val("stall_rd",    bus.out_rd, 6);
      check_val("stall_rd1",   bus.out_rd1, 32'h1234);
    end
    bus.stall_in = 1'b0;
    bus.instruction = rtype(5'd5, 5'd7, 5'd9);
    tick();
    check_val("post_stall_rd1", bus.out_rd1, 32'h5555);
    check_val("post_stall_rd2", bus.out_rd2, 32'hABCD);
    bus.stall_in = 1'b1; bus.flush = 1'b1;
    tick();
    check_val("flush_stall", bus.out_valid, 0);
    bus.stall_in = 1'b0;
    tick();
    check_val("flush_only", bus.out_valid, 0);
    bus.flush = 1'b0;

    // reset mid-stream drops the pending write
    bus.instruction = rtype(5'd10, 5'd0, 5'd8);
    bus.wb_we = 1'b1; bus.wb_reg = 5'd10; bus.wb_data = 32'h7777;
    rst_n = 1'b0;
    tick();
    check_val("mrst_valid", bus.out_valid, 0);
    check_val("mrst_rd",    bus.out_rd, 0);
    check_val("mrst_rd1",   bus.out_rd1, 0);
    check_val("mrst_opc",   bus.out_opcode, 0);
    check_val("mrst_imm",   bus.out_imm, 0);
    rst_n = 1'b1;
    bus.wb_we = 1'b0;
    bus.instruction = rtype(5'd10, 5'd5, 5'd8);
    tick();
    check_val("mrst_lost_wr", bus.out_rd1, 0);
    check_val("mrst_cleared", bus.out_rd2, 0);
    check_val("mrst_resume",  bus.out_valid, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_stage_pipe.md
DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath width; legal range is 16 or greater.
REQ-002 SHALL have parameter ZEXT_LOGIC, default 1, meaning: when 1, ANDI/ORI/XORI immediates are zero-extended; when 0, all immediates are sign-extended.
REQ-003 SHALL have parameter LOAD_OPC, default 6'h23, meaning the opcode treated as a load for hazard detection.
REQ-004 SHALL use one clock; reset is synchronous and active-low. The clock port is clk and the reset port is rst_n.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 in_valid  in  1  instruction is valid this cycle.
REQ-008 instruction  in  32  MIPS instruction word.
REQ-009 stall_in  in  1  downstream cannot accept; hold the output register.
REQ-010 flush  in  1  squash the instruction entering the output register.
REQ-011 wb_we  in  1  register-file write enable.
REQ-012 wb_reg  in  5  register-file write address.
REQ-013 wb_data  in  DATA_W  register-file write data.
REQ-014 hazard_stall  out  1  combinational; fetch must hold instruction and in_valid.
REQ-015 out_valid  out  1  output register holds a live instruction.
REQ-016 out_opcode/out_rs/out_rt/out_rd  out  6/5/5/5  registered fields [31:26]/[25:21]/[20:16]/[15:11].
REQ-017 out_rd1/out_rd2  out  DATA_W  registered register-file reads of rs/rt.
REQ-018 out_imm  out  DATA_W  registered extended instruction[15:0].

Function
REQ-019 SHALL contain 32 registers of DATA_W bits, written at the rising edge when wb_we=1; a write with wb_reg=0 SHALL be ignored.
REQ-020 Reads of register 0 SHALL return 0.
REQ-021 Write-through bypass: a read of rs or rt equal to a nonzero wb_reg while wb_we=1 SHALL return wb_data in the same cycle.
REQ-022 Immediate: opcodes 0x0C/0x0D/0x0E with ZEXT_LOGIC=1 SHALL zero-fill bits [DATA_W-1:16]; all other cases SHALL copy bit 15 into those bits.
REQ-023 hazard_stall SHALL be 1 iff in_valid & out_valid & out_opcode==LOAD_OPC & out_rt!=0 & (out_rt==instruction[25:21] | out_rt==instruction[20:16]) & !flush.
REQ-024 At each rising edge, with rst_n=1, the output register SHALL update with this priority:
- flush=1: out_valid<=0; other fields are don't-care. Flush overrides stall_in.
- else stall_in=1: all outputs hold.
- else hazard_stall=1: out_valid<=0 (bubble); other fields are don't-care.
- else: out_valid<=in_valid and all fields load from the current instruction, reads and immediate.
REQ-025 Latency: one cycle from the instruction being presented to out_valid.
REQ-026 In steady flow, throughput SHALL be one instruction per cycle.
REQ-027 Register-file writes SHALL proceed regardless of stall_in, flush or hazard_stall.
REQ-028 During stall_in, held out_rd1/out_rd2 SHALL NOT be refreshed by later writes; forwarding is downstream's responsibility.
REQ-029 hazard_stall SHALL be asserted for exactly one cycle per load-use pair when stall_in=0.

Reset
REQ-030 When rst_n=0 at a rising edge, the block SHALL clear all 32 registers, out_valid, out_opcode, out_rs, out_rt, out_rd, out_rd1, out_rd2 and out_imm to 0.
REQ-031 Reset SHALL override wb_we, flush and stall_in in the same cycle.
REQ-032 hazard_stall SHALL be 0 whenever out_valid=0, including directly after reset.

Verification
REQ-033 Write r5=0x1234 and r0=0xFFFF, then decode "add r3,r5,r0" -> next cycle out_rd1=0x1234, out_rd2=0, out_rd=3, out_valid=1.
REQ-034 Set wb_we=1, wb_reg=7, wb_data=0xABCD in the same cycle as an instruction with rs=7 -> out_rd1=0xABCD.
REQ-035 Imm 0x8001: addi -> out_imm=0xFFFF8001; ori with ZEXT_LOGIC=1 -> out_imm=0x00008001.
REQ-036 Send "lw r4,0(r1)" then "add r2,r4,r3" -> hazard_stall=1 for one cycle, then a bubble (out_valid=0), then the add is issued; with the dependent instruction using r0, there is no stall.
REQ-037 Assert stall_in for 3 cycles while the output is valid -> outputs are frozen; assert flush together with stall_in -> out_valid=0.
REQ-038 Drop rst_n for one edge while streaming with a write pending -> all outputs are 0 and the pending write is lost; the following read of that register returns 0.
